// File: rtl/arbitro_bordas_if.sv
// Handshake bundle between the edge-event arbiter and its surroundings.
// The master drives events and completion; the slave (the arbiter) returns grant and status.
interface arbitro_bordas_if #(
  parameter int unsigned CNT_W = 8
);
  logic [1:0]       evento;
  logic             fim;
  logic [1:0]       concessao;
  logic             ocupado;
  logic [1:0]       pendente;
  logic             timeout;
  logic [CNT_W-1:0] perdidos;

  modport master (
    output evento, fim,
    input  concessao, ocupado, pendente, timeout, perdidos
  );

  modport slave (
    input  evento, fim,
    output concessao, ocupado, pendente, timeout, perdidos
  );
endinterface

// File: rtl/arbitro_bordas.sv
// Two-channel round-robin arbiter turning edge pulses into pending requests
// for one shared resource, with grant timeout and saturating lost-event count.
module arbitro_bordas #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  arbitro_bordas_if.slave   bus
);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    CONCEDIDO = 2'd1,
    INTERVALO = 2'd2
  } estado_t;

  localparam logic [7:0] ULTIMO = 8'(TIMEOUT - 1);

  estado_t          estado, estado_nxt;
  logic [1:0]       concessao_r, concessao_nxt;
  logic [1:0]       pendente_r, pendente_nxt;
  logic [1:0]       grant_sel;
  logic [1:0]       descarte;
  logic             ponteiro, ponteiro_nxt;
  logic [7:0]       contador, contador_nxt;
  logic             timeout_r, timeout_nxt;
  logic [CNT_W-1:0] perdidos_r, perdidos_nxt;
  logic [CNT_W:0]   soma;
  logic [CNT_W:0]   incremento;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado      <= OCIOSO;
      concessao_r <= '0;
      pendente_r  <= '0;
      ponteiro    <= 1'b0;
      contador    <= '0;
      timeout_r   <= 1'b0;
      perdidos_r  <= '0;
    end else begin
      estado      <= estado_nxt;
      concessao_r <= concessao_nxt;
      pendente_r  <= pendente_nxt;
      ponteiro    <= ponteiro_nxt;
      contador    <= contador_nxt;
      timeout_r   <= timeout_nxt;
      perdidos_r  <= perdidos_nxt;
    end
  end

  // The pointer only advances on contention, so a lone request never
  // steals the other channel's turn.
  always_comb begin
    estado_nxt   = estado;
    grant_sel    = '0;
    ponteiro_nxt = ponteiro;
    case (estado)
      OCIOSO: begin
        if (pendente_r != 2'b00) begin
          estado_nxt = CONCEDIDO;
          case (pendente_r)
            2'b01:   grant_sel = 2'b01;
            2'b10:   grant_sel = 2'b10;
            default: begin
              grant_sel    = ponteiro ? 2'b10 : 2'b01;
              ponteiro_nxt = ~ponteiro;
            end
          endcase
        end
      end
      CONCEDIDO: begin
        if (bus.fim || (contador == ULTIMO))
          estado_nxt = INTERVALO;
      end
      INTERVALO: estado_nxt = OCIOSO;
      default:   estado_nxt = OCIOSO;
    endcase
  end

  always_comb begin
    concessao_nxt = concessao_r;
    contador_nxt  = contador;
    timeout_nxt   = 1'b0;
    case (estado)
      OCIOSO: begin
        contador_nxt  = '0;
        concessao_nxt = grant_sel;
      end
      CONCEDIDO: begin
        contador_nxt = contador + 8'd1;
        if (bus.fim) begin
          concessao_nxt = '0;
        end else if (contador == ULTIMO) begin
          concessao_nxt = '0;
          timeout_nxt   = 1'b1;
        end
      end
      INTERVALO: concessao_nxt = '0;
      default:   concessao_nxt = '0;
    endcase
  end

  // A new event on the grant edge re-arms the flag instead of being dropped.
  always_comb begin
    descarte     = bus.evento & pendente_r & ~grant_sel;
    pendente_nxt = bus.evento | (pendente_r & ~grant_sel);
    incremento   = (CNT_W+1)'({1'b0, descarte[0]} + {1'b0, descarte[1]});
    soma         = {1'b0, perdidos_r} + incremento;
    if (soma[CNT_W])
      perdidos_nxt = '1;
    else
      perdidos_nxt = soma[CNT_W-1:0];
  end

  assign bus.concessao = concessao_r;
  assign bus.ocupado   = |concessao_r;
  assign bus.pendente  = pendente_r;
  assign bus.timeout   = timeout_r;
  assign bus.perdidos  = perdidos_r;

endmodule

// File: tb/tb_arbitro_bordas.sv
// Directed bench for arbitro_bordas: reset, latency, round-robin, timeout,
// drop counting with saturation, and the fim/timeout race.
module tb_arbitro_bordas;

  logic clk;
  logic rst;
  int unsigned n_testes;
  int unsigned n_falhas;

  arbitro_bordas_if #(.CNT_W(8)) bus_a ();
  arbitro_bordas_if #(.CNT_W(2)) bus_b ();

  arbitro_bordas #(.TIMEOUT(16), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  arbitro_bordas #(.TIMEOUT(4), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic verifica(input string tag, input logic [31:0] obtido,
                          input logic [31:0] esperado);
    n_testes++;
    if (obtido !== esperado) begin
      n_falhas++;
      $display("FAIL %s: got %0h expected %0h", tag, obtido, esperado);
    end
  endtask

  task automatic passo();
    @(posedge clk);
    #1;
  endtask

  int unsigned ciclos_conc;
  int unsigned ciclos_to;
  int unsigned to_apos_conc;
  logic        conc_ant;

  initial begin
    n_testes     = 0;
    n_falhas     = 0;
    rst          = 1'b1;
    bus_a.evento = 2'b00;
    bus_a.fim    = 1'b0;
    bus_b.evento = 2'b00;
    bus_b.fim    = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    verifica("rst_conc", 32'(bus_a.concessao), 32'h0);
    verifica("rst_pend", 32'(bus_a.pendente), 32'h0);
    verifica("rst_perd", 32'(bus_a.perdidos), 32'h0);
    verifica("rst_to", 32'(bus_a.timeout), 32'h0);
    verifica("rst_ocup", 32'(bus_a.ocupado), 32'h0);

    // 1: reset in the middle of a grant
    bus_a.evento = 2'b01;
    passo();
    bus_a.evento = 2'b00;
    verifica("t1_pend", 32'(bus_a.pendente), 32'h1);
    verifica("t1_conc_lat", 32'(bus_a.concessao), 32'h0);
    passo();
    verifica("t1_conc", 32'(bus_a.concessao), 32'h1);
    verifica("t1_ocup", 32'(bus_a.ocupado), 32'h1);
    #2 rst = 1'b1;
    #1;
    verifica("t1_async_conc", 32'(bus_a.concessao), 32'h0);
    verifica("t1_async_ocup", 32'(bus_a.ocupado), 32'h0);
    verifica("t1_async_pend", 32'(bus_a.pendente), 32'h0);
    #1 rst = 1'b0;
    bus_a.evento = 2'b10;
    passo();
    bus_a.evento = 2'b00;
    passo();
    verifica("t1_after_conc", 32'(bus_a.concessao), 32'h2);
    bus_a.fim = 1'b1;
    passo();
    bus_a.fim = 1'b0;
    passo();

    // 2: single event, grant held exactly 3 cycles
    bus_a.evento = 2'b01;
    passo();
    bus_a.evento = 2'b00;
    verifica("t2_pend", 32'(bus_a.pendente), 32'h1);
    passo();
    verifica("t2_pend_clr", 32'(bus_a.pendente), 32'h0);
    verifica("t2_conc_c1", 32'(bus_a.concessao), 32'h1);
    passo();
    verifica("t2_conc_c2", 32'(bus_a.concessao), 32'h1);
    passo();
    verifica("t2_conc_c3", 32'(bus_a.concessao), 32'h1);
    bus_a.fim = 1'b1;
    passo();
    bus_a.fim = 1'b0;
    verifica("t2_interv_conc", 32'(bus_a.concessao), 32'h0);
    verifica("t2_interv_to", 32'(bus_a.timeout), 32'h0);
    verifica("t2_interv_ocup", 32'(bus_a.ocupado), 32'h0);
    passo();

    // 3: simultaneous events alternate via the pointer
    bus_a.evento = 2'b11;
    passo();
    bus_a.evento = 2'b00;
    verifica("t3_pend11", 32'(bus_a.pendente), 32'h3);
    passo();
    verifica("t3_first", 32'(bus_a.concessao), 32'h1);
    verifica("t3_pend10", 32'(bus_a.pendente), 32'h2);
    bus_a.fim = 1'b1;
    passo();
    bus_a.fim = 1'b0;
    verifica("t3_interv", 32'(bus_a.concessao), 32'h0);
    passo();
    verifica("t3_ocioso", 32'(bus_a.concessao), 32'h0);
    passo();
    verifica("t3_second", 32'(bus_a.concessao), 32'h2);
    bus_a.fim = 1'b1;
    passo();
    bus_a.fim = 1'b0;
    passo();
    bus_a.evento = 2'b11;
    passo();
    bus_a.evento = 2'b00;
    passo();
    verifica("t3_rep_first", 32'(bus_a.concessao), 32'h2);
    bus_a.fim = 1'b1;
    passo();
    bus_a.fim = 1'b0;
    passo();
    passo();
    verifica("t3_rep_second", 32'(bus_a.concessao), 32'h1);
    bus_a.fim = 1'b1;
    passo();
    bus_a.fim = 1'b0;
    passo();

    // 4: timeout after 16 granted cycles
    bus_a.evento = 2'b01;
    passo();
    bus_a.evento = 2'b00;
    ciclos_conc  = 0;
    ciclos_to    = 0;
    to_apos_conc = 0;
    conc_ant     = 1'b0;
    for (int k = 0; k < 30; k++) begin
      passo();
      if (bus_a.concessao == 2'b01) ciclos_conc++;
      if (bus_a.timeout) begin
        ciclos_to++;
        if (conc_ant) to_apos_conc++;
      end
      conc_ant = (bus_a.concessao == 2'b01);
    end
    verifica("t4_grant_len", ciclos_conc, 32'd16);
    verifica("t4_to_pulses", ciclos_to, 32'd1);
    verifica("t4_to_position", to_apos_conc, 32'd1);
    verifica("t4_pend", 32'(bus_a.pendente), 32'h0);

    // 5: dropped events
    verifica("t5_perd0", 32'(bus_a.perdidos), 32'd0);
    bus_a.evento = 2'b01;
    passo();
    passo();
    verifica("t5_grant_edge_pend", 32'(bus_a.pendente), 32'h1);
    verifica("t5_grant_edge_perd", 32'(bus_a.perdidos), 32'd0);
    passo();
    verifica("t5_drop1", 32'(bus_a.perdidos), 32'd1);
    bus_a.evento = 2'b00;
    passo();
    bus_a.evento = 2'b01;
    passo();
    passo();
    bus_a.evento = 2'b00;
    verifica("t5_drop3", 32'(bus_a.perdidos), 32'd3);
    bus_a.evento = 2'b11;
    passo();
    verifica("t5_drop4", 32'(bus_a.perdidos), 32'd4);
    passo();
    bus_a.evento = 2'b00;
    verifica("t5_drop_both", 32'(bus_a.perdidos), 32'd6);
    bus_a.fim = 1'b1;
    repeat (12) passo();
    bus_a.fim = 1'b0;
    passo();
    verifica("t5_drained", 32'(bus_a.pendente), 32'h0);

    bus_b.evento = 2'b01;
    passo();
    passo();
    passo();
    passo();
    verifica("t5_sat_mid", 32'(bus_b.perdidos), 32'd2);
    repeat (3) passo();
    bus_b.evento = 2'b00;
    verifica("t5_sat", 32'(bus_b.perdidos), 32'd3);

    // 6: fim coinciding with the last allowed cycle
    bus_a.evento = 2'b01;
    passo();
    bus_a.evento = 2'b00;
    passo();
    repeat (15) passo();
    verifica("t6_still_granted", 32'(bus_a.concessao), 32'h1);
    bus_a.fim = 1'b1;
    passo();
    bus_a.fim = 1'b0;
    verifica("t6_race_conc", 32'(bus_a.concessao), 32'h0);
    verifica("t6_race_to", 32'(bus_a.timeout), 32'h0);
    passo();
    verifica("t6_race_to_after", 32'(bus_a.timeout), 32'h0);
    bus_a.fim = 1'b1;
    passo();
    bus_a.fim = 1'b0;
    verifica("t6_fim_idle_conc", 32'(bus_a.concessao), 32'h0);
    verifica("t6_fim_idle_ocup", 32'(bus_a.ocupado), 32'h0);
    passo();
    verifica("t6_fim_idle_to", 32'(bus_a.timeout), 32'h0);
    verifica("t6_perd_kept", 32'(bus_a.perdidos), 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end

endmodule
